// File: rtl/syn_io_model.sv
// Synapse-side model of the Syn_io_if handshake: after a start request it waits a
// programmable latency, then streams one patterned result beat per channel.
module syn_io_model #(
    parameter int          DATA_W       = 128,
    parameter int          N_CHANNELS   = 2,
    parameter int          CH_W         = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
    parameter int          LATENCY      = 10,
    parameter int          PAT_CTR_W    = 8,
    parameter logic [31:0] PATTERN_BASE = 32'hAFFE_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 syn2client_valid,
    input  logic                 syn2client_ready,
    output logic [CH_W-1:0]      syn2client_channel,
    output logic [DATA_W-1:0]    syn2client_data,
    output logic [PAT_CTR_W-1:0] syn2client_pat_ctr,
    output logic                 done
);

    localparam int              N_WORDS   = DATA_W / 32;
    localparam logic [CH_W-1:0] LAST_CH   = CH_W'(N_CHANNELS - 1);
    localparam logic [7:0]      WAIT_LOAD = (LATENCY > 0) ? 8'(LATENCY - 1) : 8'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SEND} state_t;

    state_t                 r_state,     w_state_nxt;
    logic [7:0]             r_wait_cnt,  w_wait_cnt_nxt;
    logic                   r_busy,      w_busy_nxt;
    logic                   r_valid,     w_valid_nxt;
    logic [CH_W-1:0]        r_channel,   w_channel_nxt;
    logic [DATA_W-1:0]      r_data,      w_data_nxt;
    logic [PAT_CTR_W-1:0]   r_pat_ctr,   w_pat_ctr_nxt;
    logic                   r_done,      w_done_nxt;
    logic [CH_W-1:0]        w_ch_inc;

    // One 32-bit pattern word per beat, replicated across the full beat width.
    function automatic logic [DATA_W-1:0] beat_data(input logic [PAT_CTR_W-1:0] pat,
                                                    input logic [CH_W-1:0]      ch);
        logic [31:0] word;
        word = PATTERN_BASE + (32'(pat) << 8) + 32'(ch);
        return {N_WORDS{word}};
    endfunction

    assign w_ch_inc = r_channel + CH_W'(1);

    always_comb begin
        // NOTE: every next-state value gets a default first, so no path can infer a latch.
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_busy_nxt     = r_busy;
        w_valid_nxt    = r_valid;
        w_channel_nxt  = r_channel;
        w_data_nxt     = r_data;
        w_pat_ctr_nxt  = r_pat_ctr;
        w_done_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_busy_nxt = 1'b1;
                    if (LATENCY == 0) begin
                        w_state_nxt   = ST_SEND;
                        w_valid_nxt   = 1'b1;
                        w_channel_nxt = '0;
                        w_data_nxt    = beat_data(r_pat_ctr, '0);
                    end else begin
                        w_state_nxt    = ST_WAIT;
                        w_wait_cnt_nxt = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == 8'd0) begin
                    w_state_nxt   = ST_SEND;
                    w_valid_nxt   = 1'b1;
                    w_channel_nxt = '0;
                    w_data_nxt    = beat_data(r_pat_ctr, '0);
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 8'd1;
                end
            end
            ST_SEND: begin
                // Without a transfer the current beat simply holds.
                if (r_valid && syn2client_ready) begin
                    if (r_channel == LAST_CH) begin
                        w_state_nxt   = ST_IDLE;
                        w_valid_nxt   = 1'b0;
                        w_busy_nxt    = 1'b0;
                        w_channel_nxt = '0;
                        w_data_nxt    = '0;
                        w_done_nxt    = 1'b1;
                        w_pat_ctr_nxt = r_pat_ctr + PAT_CTR_W'(1);
                    end else begin
                        w_channel_nxt = w_ch_inc;
                        w_data_nxt    = beat_data(r_pat_ctr, w_ch_inc);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 8'd0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_channel  <= '0;
            r_data     <= '0;
            r_pat_ctr  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_busy     <= w_busy_nxt;
            r_valid    <= w_valid_nxt;
            r_channel  <= w_channel_nxt;
            r_data     <= w_data_nxt;
            r_pat_ctr  <= w_pat_ctr_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign busy               = r_busy;
    assign syn2client_valid   = r_valid;
    assign syn2client_channel = r_channel;
    assign syn2client_data    = r_data;
    assign syn2client_pat_ctr = r_pat_ctr;
    assign done               = r_done;

endmodule

// File: doc/syn_io_model.md
Name: syn_io_model

Overview:
Synthesizable, parametrised model of the synapse I/O side of the Syn_io_if handshake, for use in processor-level simulation and FPGA bring-up without the synapse array. On a start request it stays busy for a programmable latency. It then streams one result beat per channel to the client, under valid/ready back-pressure. A transaction counter tags every result and advances the data pattern for each transaction.

Parameters:
DATA_W, 128, result beat width in bits; must be a multiple of 32, minimum 32
N_CHANNELS, 2, beats per transaction (one per channel), 1..16
CH_W, max(1, clog2(N_CHANNELS)), channel index width
LATENCY, 10, idle-busy cycles between start acceptance and first valid beat, 0..255
PAT_CTR_W, 8, transaction (pattern) counter width
PATTERN_BASE, 32'hAFFE_0000, base word of the generated data pattern

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  transaction request, sampled only in IDLE
busy  out  1  high from start acceptance until last beat accepted
syn2client_valid  out  1  result beat valid
syn2client_ready  in  1  client accepts beat
syn2client_channel  out  CH_W  channel index of current beat
syn2client_data  out  DATA_W  result beat data
syn2client_pat_ctr  out  PAT_CTR_W  transaction number of current beat
done  out  1  one-cycle pulse after final beat accepted

Behaviour:
- Clock clk; reset is asynchronous, active-high. All state is in flops; no combinational paths from inputs to outputs.
- Reset values: busy=0, valid=0, channel=0, data=0, pat_ctr=0, done=0; FSM in IDLE; wait counter 0.
- FSM states: IDLE, WAIT, SEND.
- IDLE, start=1 at edge k: busy=1 from cycle k+1.
  - LATENCY>0: go to WAIT and load the wait counter.
  - LATENCY=0: go directly to SEND, with valid=1 at cycle k+1.
- WAIT: counts LATENCY cycles. valid rises exactly at cycle k+1+LATENCY, then the FSM is in SEND.
- SEND: presents beat ch = 0..N_CHANNELS-1 in order.
  - A beat transfers on an edge where valid && ready.
  - While valid && !ready, channel and data are held stable.
  - After a non-final transfer, the next beat is presented on the next cycle; back-to-back beats are possible with ready held high.
- Data word: w = PATTERN_BASE + (pat_ctr << 8) + ch, computed 32-bit with wrap. The word is replicated DATA_W/32 times across the beat.
- syn2client_pat_ctr is constant for the whole transaction.
- Final beat accepted at edge m, from cycle m+1:
  - valid=0, busy=0, channel=0, data=0.
  - done=1 for exactly one cycle.
  - pat_ctr incremented modulo 2^PAT_CTR_W.
  - FSM back in IDLE.
- When valid=0, data and channel are driven to 0.
- start while busy (WAIT or SEND) is ignored and not queued. start in the done cycle (IDLE) is accepted.
- Reset mid-transaction aborts immediately: all outputs return to reset values and pat_ctr returns to 0.
- ready asserted without valid has no effect.

Test Plan:
- Default params, start pulse at cycle 0, ready=1 -> busy=1 at cycles 1..12; valid at 11, 12. Beat 0: ch=0, data={4{AFFE0000}}. Beat 1: ch=1, data={4{AFFE0001}}. done=1 at cycle 13. pat_ctr=0 on both beats, 1 afterwards.
- Back-pressure: ready=0 for 3 cycles on beat 0 -> beat 0 held stable for 4 valid cycles; beat 1 follows immediately; busy stretched by 3 cycles.
- Second transaction started in the done cycle -> accepted; beats carry pat_ctr=1 with data AFFE0100, AFFE0101.
- start pulses during WAIT and SEND -> ignored; exactly 2 beats and one done pulse.
- Reset asserted during WAIT, and again during SEND with valid high -> all outputs 0 asynchronously. A subsequent start begins a fresh transaction with pat_ctr=0.
- PAT_CTR_W=2, N_CHANNELS=1, LATENCY=0, DATA_W=32 -> valid in the cycle after start. Five transactions carry pat_ctr 0,1,2,3,0 with data AFFE0000, AFFE0100, AFFE0200, AFFE0300, AFFE0000.
